// File: rtl/conv_frame_streamer.sv
// Streams a stored feature map in raster order with optional zero padding; first pixel two cycles after Start.
// Pause only withholds new issues; pixels already in flight still reach Data_Out.
module conv_frame_streamer #(
    parameter int DATA_WIDHT = 32,
    parameter int IMG_HEIGHT = 220,
    parameter int IMG_WIDTH  = 220,
    parameter int PAD        = 0,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] Base_Addr,
    input  logic                  Pause,
    output logic                  Mem_Rd_En,
    output logic [ADDR_WIDTH-1:0] Mem_Addr,
    input  logic [DATA_WIDHT-1:0] Mem_Data,
    output logic [DATA_WIDHT-1:0] Data_Out,
    output logic                  Valid_Out,
    output logic                  Busy,
    output logic                  Done
);
    localparam int OH = IMG_HEIGHT + 2 * PAD;
    localparam int OW = IMG_WIDTH + 2 * PAD;
    localparam int RW = $clog2(OH + 1);
    localparam int CW = $clog2(OW + 1);

    localparam logic [RW-1:0] R_LAST = RW'(OH - 1);
    localparam logic [RW-1:0] R_LO   = RW'(PAD);
    localparam logic [RW-1:0] R_IMG  = RW'(IMG_HEIGHT);
    localparam logic [CW-1:0] C_LAST = CW'(OW - 1);
    localparam logic [CW-1:0] C_LO   = CW'(PAD);
    localparam logic [CW-1:0] C_IMG  = CW'(IMG_WIDTH);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    logic                  rd_en_q, pad_q, last_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  s1_rd_q, s1_pad_q, s1_last_q;
    logic [DATA_WIDHT-1:0] data_q;
    logic                  valid_q, done_q;

    logic                  issue;
    logic                  in_img;
    logic                  at_last;
    logic [RW-1:0]         cur_r;
    logic [CW-1:0]         cur_c;
    logic [ADDR_WIDTH-1:0] cur_p;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        ptr_d   = ptr_q;
        issue   = 1'b0;
        cur_r   = row_q;
        cur_c   = col_q;
        cur_p   = ptr_q;

        case (state_q)
            IDLE: begin
                // The Start edge itself issues pixel (0,0) from the incoming Base_Addr.
                cur_r = '0;
                cur_c = '0;
                cur_p = Base_Addr;
                issue = Start;
            end
            STREAM: issue = !Pause;
            FLUSH:  if (done_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Offset compare: positions left of/above the image wrap to a large unsigned value.
        in_img  = ((cur_r - R_LO) < R_IMG) && ((cur_c - C_LO) < C_IMG);
        at_last = (cur_r == R_LAST) && (cur_c == C_LAST);

        if (issue) begin
            ptr_d   = in_img ? cur_p + ADDR_WIDTH'(1) : cur_p;
            state_d = at_last ? FLUSH : STREAM;
            if (cur_c == C_LAST) begin
                col_d = '0;
                row_d = (cur_r == R_LAST) ? '0 : cur_r + RW'(1);
            end else begin
                col_d = cur_c + CW'(1);
                row_d = cur_r;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            ptr_q     <= '0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            pad_q     <= 1'b0;
            last_q    <= 1'b0;
            s1_rd_q   <= 1'b0;
            s1_pad_q  <= 1'b0;
            s1_last_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            ptr_q     <= ptr_d;
            rd_en_q   <= issue && in_img;
            pad_q     <= issue && !in_img;
            last_q    <= issue && at_last;
            if (issue && in_img) addr_q <= cur_p;
            // Stage 1 lines up the pad/last tags with the memory's one-cycle read.
            s1_rd_q   <= rd_en_q;
            s1_pad_q  <= pad_q;
            s1_last_q <= last_q;
            valid_q   <= s1_rd_q || s1_pad_q;
            done_q    <= s1_last_q;
            if (s1_rd_q)       data_q <= Mem_Data;
            else if (s1_pad_q) data_q <= '0;
        end
    end

    assign Mem_Rd_En = rd_en_q;
    assign Mem_Addr  = addr_q;
    assign Data_Out  = data_q;
    assign Valid_Out = valid_q;
    assign Done      = done_q;
    assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_conv_frame_streamer.sv
module tb_conv_frame_streamer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // 4x4, PAD=0
    logic        st4, p4, rd4, v4, bz4, dn4;
    logic [15:0] b4, a4;
    logic [31:0] md4, do4;
    // 3x3, PAD=1
    logic        st3, p3, rd3, v3, bz3, dn3;
    logic [15:0] b3, a3;
    logic [31:0] md3, do3;
    // 2x2, PAD=0
    logic        st2, p2, rd2, v2, bz2, dn2;
    logic [15:0] b2, a2;
    logic [31:0] md2, do2;

    conv_frame_streamer #(.DATA_WIDHT(32), .IMG_HEIGHT(4), .IMG_WIDTH(4), .PAD(0), .ADDR_WIDTH(16)) dut4 (
        .clk(clk), .rst(rst), .Start(st4), .Base_Addr(b4), .Pause(p4),
        .Mem_Rd_En(rd4), .Mem_Addr(a4), .Mem_Data(md4),
        .Data_Out(do4), .Valid_Out(v4), .Busy(bz4), .Done(dn4));

    conv_frame_streamer #(.DATA_WIDHT(32), .IMG_HEIGHT(3), .IMG_WIDTH(3), .PAD(1), .ADDR_WIDTH(16)) dut3 (
        .clk(clk), .rst(rst), .Start(st3), .Base_Addr(b3), .Pause(p3),
        .Mem_Rd_En(rd3), .Mem_Addr(a3), .Mem_Data(md3),
        .Data_Out(do3), .Valid_Out(v3), .Busy(bz3), .Done(dn3));

    conv_frame_streamer #(.DATA_WIDHT(32), .IMG_HEIGHT(2), .IMG_WIDTH(2), .PAD(0), .ADDR_WIDTH(16)) dut2 (
        .clk(clk), .rst(rst), .Start(st2), .Base_Addr(b2), .Pause(p2),
        .Mem_Rd_En(rd2), .Mem_Addr(a2), .Mem_Data(md2),
        .Data_Out(do2), .Valid_Out(v2), .Busy(bz2), .Done(dn2));

    // Synchronous-read memories: mem[a]=a for the 4x4/2x2 maps, mem[a]=a+1 for the 3x3 map
    always @(posedge clk) begin
        if (rd4) md4 <= {16'h0, a4};
        if (rd3) md3 <= {16'h0, a3} + 32'd1;
        if (rd2) md2 <= {16'h0, a2};
    end

    logic [31:0] exp3 [25] = '{0, 0, 0, 0, 0,
                               0, 1, 2, 3, 0,
                               0, 4, 5, 6, 0,
                               0, 7, 8, 9, 0,
                               0, 0, 0, 0, 0};
    logic [15:0] exp2a [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    // One 4x4 frame; sample k is taken at the falling edge after rising edge E_k (E0 = Start edge).
    task automatic run4(input logic [15:0] base, input int pause_k, input int restart_k,
                        input int exp_last_k, input string nm);
        int nv, nd, first_k, last_k;
        nv = 0; nd = 0; first_k = -1; last_k = -1;
        @(negedge clk);
        st4 = 1'b1;
        b4  = base;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (v4) begin
                if (nv == 0) first_k = k;
                chk({nm, "_data"}, do4, 32'(base) + 32'(nv));
                nv++;
                last_k = k;
            end
            if (dn4) begin
                nd++;
                chk({nm, "_done_pos"}, 32'(nv), 32'd16);
                chk({nm, "_done_vld"}, 32'(v4), 32'd1);
            end
            if (k == 0) begin st4 = 1'b0; b4 = 16'hDEAD; end
            if (pause_k >= 0 && k == pause_k) p4 = 1'b1;
            if (pause_k >= 0 && k == pause_k + 3) p4 = 1'b0;
            if (restart_k >= 0 && k == restart_k) begin st4 = 1'b1; b4 = 16'h0500; end
            if (restart_k >= 0 && k == restart_k + 1) st4 = 1'b0;
        end
        chk({nm, "_count"}, 32'(nv), 32'd16);
        chk({nm, "_dones"}, 32'(nd), 32'd1);
        chk({nm, "_first_k"}, 32'(first_k), 32'd2);
        chk({nm, "_last_k"}, 32'(last_k), 32'(exp_last_k));
        chk({nm, "_busy_end"}, 32'(bz4), 32'd0);
    endtask

    initial begin
        int nv, nd, nrd, hit;
        logic [31:0] out3 [25];
        logic [15:0] addr2 [4];
        rst = 1'b0;
        st4 = 0; p4 = 0; b4 = 0;
        st3 = 0; p3 = 0; b3 = 0;
        st2 = 0; p2 = 0; b2 = 0;
        repeat (3) @(negedge clk);
        chk("rst_rd",    32'(rd4), 32'd0);
        chk("rst_addr",  32'(a4),  32'd0);
        chk("rst_data",  do4,      32'd0);
        chk("rst_valid", 32'(v4),  32'd0);
        chk("rst_busy",  32'(bz4), 32'd0);
        chk("rst_done",  32'(dn4), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run4(16'h0100, -1, -1, 17, "plain");
        run4(16'h0200,  4, -1, 20, "pause");
        run4(16'h0100, -1,  9, 17, "restart");

        // Reset while pixel 7 is on the output
        @(negedge clk);
        st4 = 1'b1; b4 = 16'h0100;
        nv = 0; nd = 0; hit = 0;
        for (int k = 0; k < 30 && hit == 0; k++) begin
            @(negedge clk);
            if (k == 0) st4 = 1'b0;
            if (v4) nv++;
            if (dn4) nd++;
            if (nv == 7) begin
                rst = 1'b0;
                #1;
                chk("mid_rst_rd",    32'(rd4), 32'd0);
                chk("mid_rst_addr",  32'(a4),  32'd0);
                chk("mid_rst_data",  do4,      32'd0);
                chk("mid_rst_valid", 32'(v4),  32'd0);
                chk("mid_rst_busy",  32'(bz4), 32'd0);
                chk("mid_rst_done",  32'(dn4), 32'd0);
                hit = 1;
            end
        end
        chk("mid_rst_reached", 32'(hit), 32'd1);
        chk("mid_rst_no_done", 32'(nd),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(v4), 32'd0);
        run4(16'h0300, -1, -1, 17, "fresh");

        // 3x3 image with one ring of padding
        @(negedge clk);
        st3 = 1'b1; b3 = 16'h0000;
        nv = 0; nd = 0; nrd = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 0) st3 = 1'b0;
            if (rd3) nrd++;
            if (v3) begin
                if (nv < 25) out3[nv] = do3;
                nv++;
            end
            if (dn3) nd++;
        end
        chk("pad_count", 32'(nv),  32'd25);
        chk("pad_reads", 32'(nrd), 32'd9);
        chk("pad_dones", 32'(nd),  32'd1);
        for (int i = 0; i < 25 && i < nv; i++) chk($sformatf("pad_px%0d", i), out3[i], exp3[i]);

        // 2x2 frame wrapping the address space
        @(negedge clk);
        st2 = 1'b1; b2 = 16'hFFFE;
        nrd = 0; nv = 0; nd = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k == 0) st2 = 1'b0;
            if (rd2) begin
                if (nrd < 4) addr2[nrd] = a2;
                nrd++;
            end
            if (v2) begin
                if (nv < 4) chk($sformatf("wrap_data%0d", nv), do2, {16'h0, exp2a[nv]});
                nv++;
            end
            if (dn2) nd++;
        end
        chk("wrap_reads", 32'(nrd), 32'd4);
        chk("wrap_count", 32'(nv),  32'd4);
        chk("wrap_dones", 32'(nd),  32'd1);
        for (int i = 0; i < 4 && i < nrd; i++) chk($sformatf("wrap_addr%0d", i), 32'(addr2[i]), 32'(exp2a[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
